// File: rtl/axi_id_remap_pkg.sv
// axi_id_remap_pkg: shared widths and the buffered response beat for the ID remapper response path.
package axi_id_remap_pkg;

    localparam int RESP_ID_IN_W  = 8;
    localparam int RESP_ID_OUT_W = 3;
    localparam int RESP_N_ENTRY  = 8;
    localparam int RESP_DATA_W   = 66;
    localparam int LOG_N_ENTRY   = $clog2(RESP_N_ENTRY);

    typedef struct packed {
        logic [RESP_ID_IN_W-1:0]  wide_id;
        logic [RESP_ID_OUT_W-1:0] narrow_id;
        logic                     last;
        logic                     unmapped;
        logic [RESP_DATA_W-1:0]   payload;
    } resp_beat_t;

endpackage

// File: rtl/id_resp_skid_buf.sv
// id_resp_skid_buf: 2-entry registered valid/ready FIFO over resp_beat_t.
module id_resp_skid_buf
    import axi_id_remap_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  resp_beat_t s_beat,
    output logic       m_valid,
    input  logic       m_ready,
    output resp_beat_t m_beat
);

    resp_beat_t mem [2];
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       push;
    logic       pop;

    assign s_ready = count != 2'd2;
    assign m_valid = count != 2'd0;
    assign m_beat  = mem[rd_ptr];
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/axi_id_resp_restore.sv
// axi_id_resp_restore: restores the wide master ID on B/R beats and releases the table entry after the last beat.
module axi_id_resp_restore
    import axi_id_remap_pkg::*;
#(
    parameter int ID_WIDTH_IN  = RESP_ID_IN_W,
    parameter int ID_WIDTH_OUT = RESP_ID_OUT_W,
    parameter int N_ENTRY      = RESP_N_ENTRY,
    parameter int DATA_WIDTH   = RESP_DATA_W,
    localparam int IDX_W       = $clog2(N_ENTRY)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [ID_WIDTH_OUT-1:0] s_id_i,
    input  logic                    s_last_i,
    input  logic [DATA_WIDTH-1:0]   s_payload_i,
    output logic [IDX_W-1:0]        lut_idx_o,
    input  logic [ID_WIDTH_IN-1:0]  lut_id_i,
    input  logic                    lut_valid_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [ID_WIDTH_IN-1:0]  m_id_o,
    output logic                    m_last_o,
    output logic [DATA_WIDTH-1:0]   m_payload_o,
    output logic                    release_o,
    output logic [ID_WIDTH_OUT-1:0] release_id_o,
    output logic                    err_o
);

    resp_beat_t in_beat;
    resp_beat_t out_beat;

    assign lut_idx_o = s_id_i[IDX_W-1:0];

    // The wide ID is captured at acceptance so the entry can be freed while beats are still queued.
    always_comb begin
        in_beat           = '0;
        in_beat.wide_id   = lut_valid_i ? lut_id_i : '0;
        in_beat.narrow_id = s_id_i;
        in_beat.last      = s_last_i;
        in_beat.unmapped  = ~lut_valid_i;
        in_beat.payload   = s_payload_i;
    end

    id_resp_skid_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid_i),
        .s_ready (s_ready_o),
        .s_beat  (in_beat),
        .m_valid (m_valid_o),
        .m_ready (m_ready_i),
        .m_beat  (out_beat)
    );

    assign m_id_o      = out_beat.wide_id;
    assign m_last_o    = out_beat.last;
    assign m_payload_o = out_beat.payload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            release_o    <= 1'b0;
            release_id_o <= '0;
            err_o        <= 1'b0;
        end else begin
            release_o <= m_valid_o & m_ready_i & out_beat.last & ~out_beat.unmapped;
            if (m_valid_o & m_ready_i & out_beat.last & ~out_beat.unmapped)
                release_id_o <= out_beat.narrow_id;
            err_o <= err_o | (s_valid_i & s_ready_o & ~lut_valid_i);
        end
    end

endmodule

// File: tb/tb_axi_id_resp_restore.sv
// tb_axi_id_resp_restore: directed scoreboard bench for the response ID restorer.
module tb_axi_id_resp_restore;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [2:0]  s_id_i = '0;
    logic        s_last_i = 1'b0;
    logic [65:0] s_payload_i = '0;
    logic [2:0]  lut_idx_o;
    logic [7:0]  lut_id_i;
    logic        lut_valid_i;
    logic        m_valid_o;
    logic        m_ready_i = 1'b1;
    logic [7:0]  m_id_o;
    logic        m_last_o;
    logic [65:0] m_payload_o;
    logic        release_o;
    logic [2:0]  release_id_o;
    logic        err_o;

    typedef struct {
        logic [7:0]  id;
        logic [2:0]  nid;
        logic        last;
        logic        unm;
        logic [65:0] pl;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] tbl [8];
    logic       tbl_v [8];
    int         n_checks = 0;
    int         n_fail = 0;
    int         rel_count = 0;
    logic       rel_pend = 1'b0;
    logic [2:0] rel_id = '0;
    logic [2:0] rel_last = '0;
    logic       err_exp = 1'b0;

    always #5 clk = ~clk;

    assign lut_id_i    = tbl[lut_idx_o];
    assign lut_valid_i = tbl_v[lut_idx_o];

    axi_id_resp_restore dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_id_i       (s_id_i),
        .s_last_i     (s_last_i),
        .s_payload_i  (s_payload_i),
        .lut_idx_o    (lut_idx_o),
        .lut_id_i     (lut_id_i),
        .lut_valid_i  (lut_valid_i),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_id_o       (m_id_o),
        .m_last_o     (m_last_o),
        .m_payload_o  (m_payload_o),
        .release_o    (release_o),
        .release_id_o (release_id_o),
        .err_o        (err_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, predicting what the next rising edge does.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            rel_pend = 1'b0;
            rel_last = '0;
            err_exp  = 1'b0;
            chk("rst_m_valid", m_valid_o, 0);
            chk("rst_s_ready", s_ready_o, 1);
            chk("rst_release", release_o, 0);
            chk("rst_release_id", release_id_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_m_id", m_id_o, 0);
        end else begin
            chk("release", release_o, rel_pend);
            chk("release_id", release_id_o, rel_last);
            if (release_o) rel_count++;
            chk("err", err_o, err_exp);
            chk("m_valid", m_valid_o, sb.size() != 0);
            chk("s_ready", s_ready_o, sb.size() < 2);
            if (m_valid_o && sb.size() > 0) begin
                chk("m_id", m_id_o, sb[0].id);
                chk("m_last", m_last_o, sb[0].last);
                chk("m_payload", m_payload_o, sb[0].pl);
            end
            rel_pend = 1'b0;
            if (m_valid_o && m_ready_i && sb.size() > 0) begin
                exp_t b;
                b = sb.pop_front();
                rel_pend = b.last & ~b.unm;
                if (rel_pend) rel_last = b.nid;
            end
            if (s_valid_i && s_ready_o) begin
                exp_t e;
                e.nid  = s_id_i;
                e.unm  = ~tbl_v[s_id_i];
                e.id   = tbl_v[s_id_i] ? tbl[s_id_i] : 8'h00;
                e.last = s_last_i;
                e.pl   = s_payload_i;
                sb.push_back(e);
                if (e.unm) err_exp = 1'b1;
            end
        end
    end

    task automatic send(input logic [2:0] id, input logic last, input logic [65:0] pl, output int cyc);
        s_valid_i   = 1'b1;
        s_id_i      = id;
        s_last_i    = last;
        s_payload_i = pl;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            logic acc;
            @(negedge clk);
            acc = s_ready_o;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        s_valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int rc;
        for (int i = 0; i < 8; i++) begin
            tbl[i]   = 8'h00;
            tbl_v[i] = 1'b0;
        end
        tbl[5] = 8'hA3; tbl_v[5] = 1'b1;
        tbl[2] = 8'h17; tbl_v[2] = 1'b1;
        tbl[0] = 8'h01; tbl_v[0] = 1'b1;
        tbl[7] = 8'hFE; tbl_v[7] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // B response
        rc = rel_count;
        send(3'd5, 1'b1, 66'h2, cyc);
        idle(0);
        chk("b_m_valid_t1", m_valid_o, 1);
        chk("b_m_id_t1", m_id_o, 8'hA3);
        @(posedge clk); #1;
        chk("b_release_t2", release_o, 1);
        chk("b_release_id_t2", release_id_o, 5);
        @(posedge clk); #1;
        chk("b_release_single", release_o, 0);
        idle(2);
        chk("b_rel_count", rel_count - rc, 1);

        // R burst
        rc = rel_count;
        for (int i = 0; i < 4; i++) send(3'd2, i == 3, {2'b00, 32'hC0DE0000 + i, 32'h0}, cyc);
        idle(4);
        chk("r_rel_count", rel_count - rc, 1);
        chk("r_release_id", release_id_o, 2);

        // Backpressure
        m_ready_i = 1'b0;
        send(3'd2, 1'b0, 66'h11, cyc);
        send(3'd2, 1'b0, 66'h22, cyc);
        s_valid_i = 1'b1; s_id_i = 3'd2; s_last_i = 1'b1; s_payload_i = 66'h33;
        repeat (3) begin
            @(negedge clk);
            chk("bp_s_ready_low", s_ready_o, 0);
            chk("bp_head_held", m_payload_o, 66'h11);
        end
        @(posedge clk); #1;
        m_ready_i = 1'b1;
        send(3'd2, 1'b1, 66'h33, cyc);
        idle(4);
        chk("bp_drained", m_valid_o, 0);

        // Unmapped
        rc = rel_count;
        send(3'd4, 1'b1, 66'h44, cyc);
        idle(0);
        chk("unm_m_id", m_id_o, 0);
        idle(4);
        chk("unm_err_sticky", err_o, 1);
        chk("unm_no_release", rel_count - rc, 0);

        // Full throughput
        rc = rel_count;
        for (int i = 0; i < 6; i++) begin
            send((i % 2) ? 3'd7 : 3'd0, 1'b1, 66'(100 + i), cyc);
            chk("tput_one_cycle", cyc, 1);
        end
        idle(4);
        chk("tput_rel_count", rel_count - rc, 6);

        // Reset mid-burst
        m_ready_i = 1'b0;
        send(3'd2, 1'b0, 66'h55, cyc);
        send(3'd2, 1'b1, 66'h66, cyc);
        s_valid_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid_o, 0);
        chk("mid_rst_s_ready", s_ready_o, 1);
        chk("mid_rst_err", err_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ready_i = 1'b1;
        rc = rel_count;
        idle(4);
        chk("post_rst_no_release", rel_count - rc, 0);
        chk("post_rst_m_valid", m_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
